// File: rtl/crt_53_pkg.sv
// Shared constants and FSM state type for the mod-53 / mod-64 CRT residue decoder.
package crt_53_pkg;

  localparam int MOD      = 53;
  localparam int MOD_INV  = 29;
  localparam int INV_BITS = 5;
  localparam int RES_W    = 6;
  localparam int OUT_W    = 12;

  localparam logic [RES_W-1:0] MOD_R   = MOD[RES_W-1:0];
  // Padded to 8 bits so a 3-bit step index never selects outside the vector.
  localparam logic [7:0]       INV_VEC = MOD_INV[7:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIFF = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } crt_state_e;

endpackage

// File: rtl/crt_53_64_decode_mod53_dbl_add.sv
// Combinational (2*acc + (add ? d : 0)) mod 53; one step of the MSB-first constant multiply.
module mod53_dbl_add
  import crt_53_pkg::*;
(
  input  logic [RES_W-1:0] i_acc,
  input  logic [RES_W-1:0] i_d,
  input  logic             i_add,
  output logic [RES_W-1:0] o_sum
);

  localparam logic [7:0] M1 = MOD[7:0];
  localparam logic [7:0] M2 = 8'(2 * MOD);

  logic [7:0] w_sum;

  // Both operands are below 53, so the sum is at most 156 and one conditional subtract suffices.
  always_comb begin
    w_sum = {1'b0, i_acc, 1'b0} + (i_add ? {2'b00, i_d} : 8'd0);
    if (w_sum >= M2)
      o_sum = RES_W'(w_sum - M2);
    else if (w_sum >= M1)
      o_sum = RES_W'(w_sum - M1);
    else
      o_sum = RES_W'(w_sum);
  end

endmodule

// File: rtl/crt_53_64_decode.sv
// Residue pair (X mod 53, X mod 64) to binary X via mixed-radix CRT with a serial constant multiply.
// Optional macro CRT_RANGE_CHECK_EN: flag r53 >= 53 on err (x forced to 0) instead of reducing it.
module crt_53_64_decode
  import crt_53_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] r53,
  input  logic [RES_W-1:0] r64,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] x,
  output logic             err,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // ready never depends on valid, and x/err hold while out_valid=1 and out_ready=0.

  crt_state_e       r_state;
  crt_state_e       w_next;
  logic [RES_W-1:0] r_r53;
  logic [RES_W-1:0] r_r64;
  logic [RES_W-1:0] r_d;
  logic [RES_W-1:0] r_acc;
  logic [2:0]       r_step;
`ifdef CRT_RANGE_CHECK_EN
  logic             r_bad;
`endif

  logic [RES_W-1:0] w_r53_eff;
  logic [RES_W-1:0] w_b;
  logic [RES_W-1:0] w_d;
  logic [RES_W-1:0] w_acc_next;
  logic             w_bit;

  always_comb begin
    w_b = (r_r64 >= MOD_R) ? r_r64 - MOD_R : r_r64;
`ifdef CRT_RANGE_CHECK_EN
    w_r53_eff = r_r53;
`else
    w_r53_eff = (r_r53 >= MOD_R) ? r_r53 - MOD_R : r_r53;
`endif
    // Wrap-around in 6 bits is harmless: the true difference always lies in 0..52.
    w_d   = (w_r53_eff >= w_b) ? w_r53_eff - w_b : w_r53_eff + MOD_R - w_b;
    w_bit = INV_VEC[r_step];
  end

  mod53_dbl_add u_dbl_add (
    .i_acc (r_acc),
    .i_d   (r_d),
    .i_add (w_bit),
    .o_sum (w_acc_next)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)       w_next = ST_DIFF;
      ST_DIFF:                     w_next = ST_MUL;
      ST_MUL:  if (r_step == 3'd0) w_next = ST_DONE;
      ST_DONE: if (out_ready)      w_next = ST_IDLE;
      default:                     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_r53   <= '0;
      r_r64   <= '0;
      r_d     <= '0;
      r_acc   <= '0;
      r_step  <= '0;
`ifdef CRT_RANGE_CHECK_EN
      r_bad   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_r53 <= r53;
            r_r64 <= r64;
`ifdef CRT_RANGE_CHECK_EN
            r_bad <= (r53 >= MOD_R);
`endif
          end
        end
        ST_DIFF: begin
          r_d    <= w_d;
          r_acc  <= '0;
          r_step <= 3'(INV_BITS - 1);
        end
        ST_MUL: begin
          r_acc <= w_acc_next;
          if (r_step != 3'd0) r_step <= r_step - 3'd1;
        end
        ST_DONE: begin
`ifdef CRT_RANGE_CHECK_EN
          if (out_ready) r_bad <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = rst_n && (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
    dbg_state = r_state;
`ifdef CRT_RANGE_CHECK_EN
    x   = r_bad ? '0 : {r_acc, r_r64};
    err = r_bad && out_valid;
`else
    x   = {r_acc, r_r64};
    err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_crt_53_64_decode.sv
// Bench for crt_53_64_decode: CRT search model, per-cycle compare, directed literals, sweep, random traffic.
module tb_crt_53_64_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  r53;
  logic [5:0]  r64;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] x;
  logic        err;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  crt_53_64_decode dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r53       (r53),
    .r64       (r64),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .err       (err),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: find the unique k in 0..52 with (r64 + 64k) mod 53 == r53.
  function automatic logic [11:0] crt_ref(input int a, input int b);
    for (int k = 0; k < 53; k++)
      if ((b + 64 * k) % 53 == a) return 12'(b + 64 * k);
    return 12'hfff;
  endfunction

  // ---------------- model + compare process ----------------
  bit          mon_on = 1'b0;
  bit          b2b    = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_err  = 1'b0;
  int          m_cnt  = 0;
  logic [11:0] m_x    = '0;
  int          cyc    = 0;
  int          last_acc = -1;

  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      chk("in_ready",  in_ready,  rst_n && !m_busy);
      chk("out_valid", out_valid, m_valid);
      chk("err",       err,       m_valid && m_err);
      if (m_valid) chk("x", x, m_x);
    end
    // Predict the state after the coming rising edge.
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_err = 0; m_cnt = 0;
    end else if (m_valid) begin
      if (out_ready) begin m_valid = 0; m_busy = 0; end
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) m_valid = 1;
    end else if (in_valid) begin
      if (mon_on && b2b && last_acc >= 0) chk("accept_interval", cyc - last_acc, 8);
      last_acc = b2b ? cyc : -1;
      m_busy = 1;
      m_cnt  = 6;
`ifdef CRT_RANGE_CHECK_EN
      m_err = (r53 >= 53);
      m_x   = m_err ? 12'd0 : crt_ref(r53, r64);
`else
      m_err = 0;
      m_x   = crt_ref((r53 >= 53) ? r53 - 53 : r53, r64);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_accept(output bit got);
    int n = 0;
    got = 0;
    while (n < 40 && !got) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic send(input logic [5:0] a, input logic [5:0] b,
                      input logic [11:0] ex, input logic ee, input string nm);
    bit got;
    int lat = 0;
    r53 = a; r64 = b; in_valid = 1'b1;
    wait_accept(got);
    in_valid = 1'b0;
    if (!got) begin
      chk({nm, "_accept_timeout"}, 0, 1);
      return;
    end
    got = 0;
    while (lat < 30 && !got) begin
      @(negedge clk);
      lat++;
      got = out_valid;
    end
    chk({nm, "_latency"}, lat, 7);
    if (got) begin
      chk({nm, "_x"}, x, ex);
      chk({nm, "_err"}, err, ee);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit got;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; r53 = '0; r64 = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1'b1;
    @(negedge clk);
    chk("rst_x", x, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed decodes with a free-running sink.
    out_ready = 1'b1;
    send(6'd0,  6'd0,  12'd0,    1'b0, "d_0_0");
    send(6'd11, 6'd0,  12'd64,   1'b0, "d_11_0");
    send(6'd0,  6'd53, 12'd53,   1'b0, "d_0_53");
    send(6'd52, 6'd63, 12'd3391, 1'b0, "d_max");
    send(6'd46, 6'd40, 12'd1000, 1'b0, "d_46_40");
`ifdef CRT_RANGE_CHECK_EN
    send(6'd60, 6'd5,  12'd0,    1'b1, "d_range");
`else
    send(6'd60, 6'd5,  12'd325,  1'b0, "d_range");
`endif

    // Backpressure: sink stalls 20 cycles with the result presented.
    out_ready = 1'b0;
    send(6'd7, 6'd5, 12'd325, 1'b0, "bp");
    repeat (20) begin
      @(negedge clk);
      chk("bp_hold_x", x, 325);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset during the third MUL cycle abandons the conversion.
    r53 = 6'd46; r64 = 6'd40; in_valid = 1'b1;
    wait_accept(got);
    in_valid = 1'b0;
    chk("mr_accept", got, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_out_valid", out_valid, 0);
    repeat (12) @(posedge clk);
    #1;

    // Exhaustive back-to-back sweep of every in-range pair.
    b2b = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    got = 1;
    for (int a = 0; a < 53 && got; a++) begin
      for (int b = 0; b < 64 && got; b++) begin
        r53 = 6'(a); r64 = 6'(b);
        wait_accept(got);
        if (!got) chk("sweep_accept_timeout", 0, 1);
      end
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1 b2b = 1'b0;

    // Random traffic: full 6-bit residues, bursty valid, random sink stalls.
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      r53       = 6'($urandom_range(0, 63));
      r64       = 6'($urandom_range(0, 63));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
